// File: rtl/b2ins_if.sv
// Serial-side bundle between the BIP-24 calculator / bit source and the B2 inserter.
interface b2ins_if;
  logic        sdi;
  logic        sof;
  logic [23:0] b2pdo;
  logic        b2vld;
  logic [23:0] errmask;
  logic        sdo;
  logic        sofo;
  logic        b2act;
  logic        b2miss;

  modport master (
    output sdi, sof, b2pdo, b2vld, errmask,
    input  sdo, sofo, b2act, b2miss
  );

  modport slave (
    input  sdi, sof, b2pdo, b2vld, errmask,
    output sdo, sofo, b2act, b2miss
  );
endinterface

// File: rtl/b2ins.sv
// STM-1 serial B2 insertion: overwrites frame bits B2_BIT_START.. with the captured
// (optionally masked) BIP-24 word; everything else passes through with one clock of latency.
module b2ins #(
  parameter int unsigned FRAME_BITS   = 19440,
  parameter int unsigned B2_BIT_START = 8640,
  parameter int unsigned B2_BITS      = 24
) (
  input  logic   clk155,
  input  logic   rst,
  b2ins_if.slave bus
);

  localparam logic [14:0] LastBit = 15'(FRAME_BITS - 1);
  localparam logic [14:0] WinLo   = 15'(B2_BIT_START);
  localparam logic [14:0] WinHi   = 15'(B2_BIT_START + B2_BITS - 1);

  logic [14:0] bitcnt_q, bitcnt_d;
  logic [23:0] b2reg_q, b2reg_d;
  logic [23:0] maskreg_q, maskreg_d;
  logic        capd_q, capd_d;
  logic        run_q, run_d;
  logic        sdo_q, sdo_d;
  logic        sofo_q, sofo_d;
  logic        b2act_q, b2act_d;
  logic        b2miss_q, b2miss_d;

  logic        in_win;
  logic [4:0]  bit_idx;

  // A sof cycle is frame bit 0, so it never falls inside the window and aborts any open one.
  assign in_win  = run_q && !bus.sof && (bitcnt_q >= WinLo) && (bitcnt_q <= WinHi);
  assign bit_idx = 5'(bitcnt_q - WinLo);

  always_comb begin
    bitcnt_d  = bitcnt_q;
    b2reg_d   = b2reg_q;
    maskreg_d = maskreg_q;
    capd_d    = capd_q;
    run_d     = run_q;

    if (bus.b2vld && !capd_q && !bus.sof) begin
      b2reg_d = bus.b2pdo;
      capd_d  = 1'b1;
    end

    if (bus.sof) begin
      bitcnt_d  = 15'd1;
      run_d     = 1'b1;
      capd_d    = 1'b0;
      maskreg_d = bus.errmask;
    end else if (run_q) begin
      // Flywheel: keep framing even when sof goes missing.
      if (bitcnt_q == LastBit) begin
        bitcnt_d = 15'd0;
        capd_d   = 1'b0;
      end else begin
        bitcnt_d = bitcnt_q + 15'd1;
      end
    end

    sdo_d    = in_win ? (b2reg_q[bit_idx] ^ maskreg_q[bit_idx]) : bus.sdi;
    b2act_d  = in_win;
    sofo_d   = bus.sof;
    b2miss_d = run_q && !bus.sof && (bitcnt_q == WinLo) && !capd_q;
  end

  always_ff @(posedge clk155 or posedge rst) begin
    if (rst) begin
      bitcnt_q  <= '0;
      b2reg_q   <= '0;
      maskreg_q <= '0;
      capd_q    <= 1'b0;
      run_q     <= 1'b0;
      sdo_q     <= 1'b0;
      sofo_q    <= 1'b0;
      b2act_q   <= 1'b0;
      b2miss_q  <= 1'b0;
    end else begin
      bitcnt_q  <= bitcnt_d;
      b2reg_q   <= b2reg_d;
      maskreg_q <= maskreg_d;
      capd_q    <= capd_d;
      run_q     <= run_d;
      sdo_q     <= sdo_d;
      sofo_q    <= sofo_d;
      b2act_q   <= b2act_d;
      b2miss_q  <= b2miss_d;
    end
  end

  assign bus.sdo    = sdo_q;
  assign bus.sofo   = sofo_q;
  assign bus.b2act  = b2act_q;
  assign bus.b2miss = b2miss_q;

endmodule

// File: tb/tb_b2ins.sv
// Bench for b2ins: table of inserted words plus multi-frame corner sequences, all checked
// cycle by cycle against a frame-position reference model.
module tb_b2ins;
  localparam int FB = 19440;
  localparam int BS = 8640;
  localparam int BB = 24;

  logic clk155 = 1'b0;
  logic rst    = 1'b1;
  always #5 clk155 = ~clk155;

  b2ins_if bus ();

  b2ins dut (
    .clk155 (clk155),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [23:0] pdo;
    logic [23:0] mask;
    logic [23:0] exp_word;
    bit          ones;
  } vec_t;

  vec_t tab [4];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position of the current sdi bit in its frame (-1 = never framed).
  int          m_pos;
  logic [23:0] m_word;
  logic [23:0] m_mask;
  bit          m_got;

  int          act_cnt;
  int          miss_cnt;
  int          win_idx;
  logic [23:0] win_word;
  bit          all_ones;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 25) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = -1;
    m_word = '0;
    m_mask = '0;
    m_got  = 1'b0;
  endtask

  task automatic tick();
    logic e_sdo, e_act, e_miss, e_sofo;
    bit   in_win;
    in_win = !bus.sof && m_pos >= BS && m_pos < BS + BB;
    e_sdo  = in_win ? (m_word[m_pos-BS] ^ m_mask[m_pos-BS]) : bus.sdi;
    e_act  = in_win;
    e_sofo = bus.sof;
    e_miss = !bus.sof && m_pos == BS && !m_got;
    if (!bus.sof && bus.b2vld && !m_got) begin
      m_word = bus.b2pdo;
      m_got  = 1'b1;
    end
    if (bus.sof) begin
      m_pos  = 1;
      m_got  = 1'b0;
      m_mask = bus.errmask;
    end else if (m_pos >= 0) begin
      m_pos = (m_pos + 1) % FB;
      if (m_pos == 0) m_got = 1'b0;
    end
    @(posedge clk155);
    #1;
    check("sdo", 32'(bus.sdo), 32'(e_sdo));
    check("sofo", 32'(bus.sofo), 32'(e_sofo));
    check("b2act", 32'(bus.b2act), 32'(e_act));
    check("b2miss", 32'(bus.b2miss), 32'(e_miss));
    if (bus.b2act) begin
      if (win_idx < BB) win_word[win_idx] = bus.sdo;
      win_idx++;
      act_cnt++;
    end
    if (bus.b2miss) miss_cnt++;
    // Next cycle's stimulus: sof and b2vld default low, data random unless all-ones requested.
    bus.sof     = 1'b0;
    bus.b2vld   = 1'b0;
    bus.sdi     = all_ones ? 1'b1 : 1'($urandom_range(0, 1));
    bus.b2pdo   = 24'($urandom);
    bus.errmask = 24'($urandom);
  endtask

  task automatic clear_stats();
    act_cnt  = 0;
    miss_cnt = 0;
    win_idx  = 0;
    win_word = '0;
  endtask

  // sof with a decoy b2vld on the same cycle (sof must win), then the real word for 8 clocks.
  task automatic start_frame(input logic [23:0] word, input logic [23:0] mask, input bit vld);
    bus.sof     = 1'b1;
    bus.errmask = mask;
    bus.b2vld   = vld;
    bus.b2pdo   = ~word;
    tick();
    for (int c = 1; c <= 8; c++) begin
      bus.b2vld = vld;
      bus.b2pdo = word;
      tick();
    end
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_pos != target && guard < FB + 10) begin
      tick();
      guard++;
    end
    check("run_to_bound", 32'(m_pos), 32'(target));
  endtask

  initial begin
    tab[0] = '{pdo: 24'hA5C33C, mask: 24'h000000, exp_word: 24'hA5C33C, ones: 1'b1};
    tab[1] = '{pdo: 24'hA5C33C, mask: 24'hFFFFFF, exp_word: 24'h5A3CC3, ones: 1'b0};
    tab[2] = '{pdo: 24'h123456, mask: 24'h00F00F, exp_word: 24'h12C459, ones: 1'b0};
    tab[3] = '{pdo: 24'hFFFFFF, mask: 24'h800001, exp_word: 24'h7FFFFE, ones: 1'b0};

    all_ones    = 1'b0;
    bus.sdi     = 1'b0;
    bus.sof     = 1'b0;
    bus.b2vld   = 1'b0;
    bus.b2pdo   = '0;
    bus.errmask = '0;
    model_reset();
    clear_stats();

    #12;
    check("rst_sdo", 32'(bus.sdo), 32'd0);
    check("rst_sofo", 32'(bus.sofo), 32'd0);
    check("rst_b2act", 32'(bus.b2act), 32'd0);
    check("rst_b2miss", 32'(bus.b2miss), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) tick();

    // Table: each frame's window must carry b2pdo ^ errmask, b2reg[0] first, for 24 clocks.
    for (int i = 0; i < 4; i++) begin
      all_ones = tab[i].ones;
      clear_stats();
      start_frame(tab[i].pdo, tab[i].mask, 1'b1);
      run_to(BS + BB + 2);
      check($sformatf("win_word[%0d]", i), 32'(win_word), 32'(tab[i].exp_word));
      check($sformatf("act_cnt[%0d]", i), act_cnt, 32'd24);
      check($sformatf("miss_cnt[%0d]", i), miss_cnt, 32'd0);
    end
    all_ones = 1'b0;

    // No b2vld, then no further sof: stale word inserted, miss in both frames across the wrap.
    clear_stats();
    start_frame(24'h0, 24'h0, 1'b0);
    run_to(BS + BB + 2);
    check("stale_word", 32'(win_word), 32'(tab[3].pdo));
    check("miss_first", miss_cnt, 32'd1);
    run_to(0);
    run_to(BS + BB + 2);
    check("fly_act_cnt", act_cnt, 32'd48);
    check("fly_miss_cnt", miss_cnt, 32'd2);

    // sof at frame bit 8650 aborts the window after 10 inserted bits.
    clear_stats();
    start_frame(24'h3C5A96, 24'h0, 1'b1);
    run_to(BS + 10);
    start_frame(24'h0F1E2D, 24'h0, 1'b1);
    check("abort_act_cnt", act_cnt, 32'd10);
    run_to(BS + 5);
    check("resync_act_cnt", act_cnt, 32'd15);
    check("pre_rst_b2act", 32'(bus.b2act), 32'd1);

    // Asynchronous reset inside the window clears outputs before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("async_sdo", 32'(bus.sdo), 32'd0);
    check("async_sofo", 32'(bus.sofo), 32'd0);
    check("async_b2act", 32'(bus.b2act), 32'd0);
    check("async_b2miss", 32'(bus.b2miss), 32'd0);
    @(posedge clk155);
    #2 rst = 1'b0;
    model_reset();
    clear_stats();
    for (int c = 0; c < BS + 60; c++) begin
      if (c >= 3 && c < 9) bus.b2vld = 1'b1;
      tick();
    end
    check("post_rst_act", act_cnt, 32'd0);
    check("post_rst_miss", miss_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
